udp_tx_packetizer: RTL

UDP_TX_PACKETIZER -- requirements
Module: udp_tx_packetizer

---
 rtl/udp_tx_packetizer_if.sv | 21 ++
 rtl/udp_tx_packetizer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx_packetizer_if.sv
// AXI-Stream style byte interface used on both sides of udp_tx_packetizer.
//   tdata  : payload byte
//   tvalid : source has a beat
//   tready : sink can take a beat
//   tlast  : final beat of a frame
//   tuser  : sideband; on the input side tuser=1 with tlast=1 marks a bad frame
// A beat transfers on a rising clk edge where tvalid && tready are both 1.
// Once tvalid is raised, tdata/tlast/tuser are held until that transfer.
interface AXIS_IF #(
  parameter int TDATA_WIDTH = 8,
  parameter int TUSER_WIDTH = 1
);
  logic [TDATA_WIDTH-1:0] tdata;
  logic                   tvalid;
  logic                   tready;
  logic                   tlast;
  logic [TUSER_WIDTH-1:0] tuser;

  modport Transmitter (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport Receiver    (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/udp_tx_packetizer.sv
// udp_tx_packetizer: buffers a raw byte stream into UDP datagrams.
// Bytes are written to a payload RAM until tlast, MAX_PAYLOAD bytes, or an
// idle timeout closes the datagram. The header (length = payload + 8, zero
// checksum, latched config) is then offered, and after it is accepted the
// payload is replayed from RAM on m_axis with tlast on the final byte.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   s_axis              : byte stream in (tuser=1 on the tlast beat drops it)
//   m_udp_hdr_*/m_udp_* : UDP header handshake and fields
//   m_axis              : UDP payload out (tuser always 0)
//   local_ip .. ttl     : configuration, sampled when a datagram closes
//   busy                : not IDLE
//   drop_pulse          : one cycle per discarded datagram
//   tx_count            : headers accepted, wrapping
//   dbg_state           : current FSM state
// Handshakes: a transfer happens on a clk edge where valid && ready; valid
// and its data stay stable until then.
module udp_tx_packetizer #(
  parameter int MAX_PAYLOAD    = 1472,
  parameter int BUFFER_DEPTH   = 2048,
  parameter int TIMEOUT_CYCLES = 125000
) (
  input  logic               clk,
  input  logic               reset,
  AXIS_IF.Receiver           s_axis,
  output logic               m_udp_hdr_valid,
  input  logic               m_udp_hdr_ready,
  output logic [5:0]         m_udp_ip_dscp,
  output logic [1:0]         m_udp_ip_ecn,
  output logic [7:0]         m_udp_ip_ttl,
  output logic [31:0]        m_udp_ip_source_ip,
  output logic [31:0]        m_udp_ip_dest_ip,
  output logic [15:0]        m_udp_source_port,
  output logic [15:0]        m_udp_dest_port,
  output logic [15:0]        m_udp_length,
  output logic [15:0]        m_udp_checksum,
  AXIS_IF.Transmitter        m_axis,
  input  logic [31:0]        local_ip,
  input  logic [31:0]        dest_ip,
  input  logic [15:0]        source_port,
  input  logic [15:0]        dest_port,
  input  logic [7:0]         ttl,
  output logic               busy,
  output logic               drop_pulse,
  output logic [15:0]        tx_count,
  output logic [1:0]         dbg_state
);
  localparam int AW = $clog2(BUFFER_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] MAX_V     = CW'(MAX_PAYLOAD);
  localparam logic [TW-1:0] TIMEOUT_V = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, FILL, HEADER, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] byte_count_q, byte_count_d;
  logic [CW-1:0] rd_ptr_q, rd_ptr_d;
  logic [TW-1:0] idle_q, idle_d;
  logic [15:0]   tx_count_q, tx_count_d;
  logic          in_ready_q, in_ready_d;
  logic          hdr_valid_q, hdr_valid_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic          drop_q, drop_d;
  logic [15:0]   len_q, len_d;
  logic [31:0]   sip_q, sip_d, dip_q, dip_d;
  logic [15:0]   sport_q, sport_d, dport_q, dport_d;
  logic [7:0]    ttl_q, ttl_d;

  logic [7:0]    mem [BUFFER_DEPTH];
  logic [7:0]    rd_data_q;
  logic          wr_en, rd_en, accept, close_en;
  logic [CW-1:0] close_len, bc_inc;
  logic [TW-1:0] idle_inc;

  always_comb begin
    state_d      = state_q;
    byte_count_d = byte_count_q;
    rd_ptr_d     = rd_ptr_q;
    idle_d       = idle_q;
    tx_count_d   = tx_count_q;
    in_ready_d   = in_ready_q;
    hdr_valid_d  = hdr_valid_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    drop_d       = 1'b0;
    len_d        = len_q;
    sip_d        = sip_q;
    dip_d        = dip_q;
    sport_d      = sport_q;
    dport_d      = dport_q;
    ttl_d        = ttl_q;
    wr_en        = 1'b0;
    rd_en        = 1'b0;
    close_en     = 1'b0;
    close_len    = byte_count_q;
    accept       = s_axis.tvalid && in_ready_q;
    bc_inc       = byte_count_q + CW'(1);
    idle_inc     = idle_q + TW'(1);

    case (state_q)
      IDLE, FILL: begin
        in_ready_d = 1'b1;
        if (accept) begin
          wr_en  = 1'b1;
          idle_d = '0;
          if (s_axis.tlast && s_axis.tuser[0]) begin
            // Bad frame: throw away everything gathered so far.
            drop_d       = 1'b1;
            byte_count_d = '0;
            state_d      = IDLE;
          end else if (s_axis.tlast || bc_inc == MAX_V) begin
            close_en  = 1'b1;
            close_len = bc_inc;
          end else begin
            byte_count_d = bc_inc;
            state_d      = FILL;
          end
        end else if (state_q == FILL && TIMEOUT_CYCLES != 0) begin
          // FILL always holds at least one byte, so a timeout close is never empty.
          if (idle_inc == TIMEOUT_V) begin
            close_en  = 1'b1;
            close_len = byte_count_q;
          end else begin
            idle_d = idle_inc;
          end
        end
      end
      HEADER: begin
        if (m_udp_hdr_ready) begin
          hdr_valid_d = 1'b0;
          tx_count_d  = tx_count_q + 16'd1;
          rd_ptr_d    = '0;
          state_d     = DRAIN;
        end
      end
      DRAIN: begin
        if (out_valid_q && m_axis.tready && out_last_q) begin
          out_valid_d  = 1'b0;
          out_last_d   = 1'b0;
          byte_count_d = '0;
          in_ready_d   = 1'b1;
          state_d      = IDLE;
        end else if (rd_ptr_q != byte_count_q && (!out_valid_q || m_axis.tready)) begin
          // Output register is empty or being emptied: fetch the next byte.
          rd_en       = 1'b1;
          out_valid_d = 1'b1;
          out_last_d  = (rd_ptr_q + CW'(1) == byte_count_q);
          rd_ptr_d    = rd_ptr_q + CW'(1);
        end else if (out_valid_q && m_axis.tready) begin
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (close_en) begin
      state_d      = HEADER;
      byte_count_d = close_len;
      idle_d       = '0;
      in_ready_d   = 1'b0;
      hdr_valid_d  = 1'b1;
      len_d        = 16'(close_len) + 16'd8;
      sip_d        = local_ip;
      dip_d        = dest_ip;
      sport_d      = source_port;
      dport_d      = dest_port;
      ttl_d        = ttl;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      byte_count_q <= '0;
      rd_ptr_q     <= '0;
      idle_q       <= '0;
      tx_count_q   <= '0;
      in_ready_q   <= 1'b0;
      hdr_valid_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      drop_q       <= 1'b0;
      len_q        <= '0;
      sip_q        <= '0;
      dip_q        <= '0;
      sport_q      <= '0;
      dport_q      <= '0;
      ttl_q        <= '0;
    end else begin
      state_q      <= state_d;
      byte_count_q <= byte_count_d;
      rd_ptr_q     <= rd_ptr_d;
      idle_q       <= idle_d;
      tx_count_q   <= tx_count_d;
      in_ready_q   <= in_ready_d;
      hdr_valid_q  <= hdr_valid_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      drop_q       <= drop_d;
      len_q        <= len_d;
      sip_q        <= sip_d;
      dip_q        <= dip_d;
      sport_q      <= sport_d;
      dport_q      <= dport_d;
      ttl_q        <= ttl_d;
    end
  end

  // Payload RAM, not reset; the read port is registered so it maps to block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[byte_count_q[AW-1:0]] <= s_axis.tdata;
    if (rd_en) rd_data_q <= mem[rd_ptr_q[AW-1:0]];
  end

  assign s_axis.tready      = in_ready_q;
  assign m_axis.tvalid      = out_valid_q;
  assign m_axis.tdata       = rd_data_q;
  assign m_axis.tlast       = out_last_q;
  assign m_axis.tuser       = '0;
  assign m_udp_hdr_valid    = hdr_valid_q;
  assign m_udp_ip_dscp      = 6'd0;
  assign m_udp_ip_ecn       = 2'd0;
  assign m_udp_checksum     = 16'd0;
  assign m_udp_ip_ttl       = ttl_q;
  assign m_udp_ip_source_ip = sip_q;
  assign m_udp_ip_dest_ip   = dip_q;
  assign m_udp_source_port  = sport_q;
  assign m_udp_dest_port    = dport_q;
  assign m_udp_length       = len_q;
  assign busy               = (state_q != IDLE);
  assign drop_pulse         = drop_q;
  assign tx_count           = tx_count_q;
  assign dbg_state          = state_q;
endmodule
